// File: rtl/qam16_coherent_demod.sv
`default_nettype none
// ============================================================================
// Module  : qam16_coherent_demod
// Brief   : Coherent 16-QAM demodulator. Mixes the sample stream with a
//           4-phase carrier, integrates and dumps per symbol, slices I/Q to
//           Gray dibits and serialises 4 bits per symbol, MSB first.
// Revision: 1.0 - initial release
// ============================================================================
module qam16_coherent_demod #(
    parameter int IN_W    = 9,
    parameter int SPS     = 16,
    parameter int LEVEL_A = 32
) (
    input  logic                   carrier_clk,
    input  logic                   reset,
    input  logic signed [IN_W-1:0] signal,
    input  logic                   sample_valid,
    input  logic                   sym_start,
    output logic [1:0]             sym_i,
    output logic [1:0]             sym_q,
    output logic                   sym_valid,
    output logic                   bit_out,
    output logic                   bit_valid,
    output logic                   sync_err
);

    localparam int ACC_W = IN_W + $clog2(SPS);
    localparam int TH    = LEVEL_A * SPS;
    localparam int IDX_W = $clog2(SPS);

    localparam logic signed [ACC_W-1:0] c_TH_POS = ACC_W'(TH);
    localparam logic signed [ACC_W-1:0] c_TH_NEG = ACC_W'(-TH);
    localparam logic signed [ACC_W-1:0] c_ZERO   = '0;
    localparam logic [IDX_W-1:0]        c_IDX_LAST = IDX_W'(SPS - 1);
    localparam logic [IDX_W-1:0]        c_IDX_ONE  = IDX_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACQ  = 2'd1;
    localparam logic [1:0] S_DUMP = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [IDX_W-1:0]        r_idx;        // index the next accepted sample gets
    logic signed [ACC_W-1:0] r_acc_i;
    logic signed [ACC_W-1:0] r_acc_q;
    logic signed [ACC_W-1:0] w_acc_i_nxt;
    logic signed [ACC_W-1:0] w_acc_q_nxt;
    logic signed [ACC_W-1:0] w_s_ext;
    logic                    w_take;       // sample is consumed this cycle
    logic                    w_first;      // consumed sample is index 0
    logic                    w_abort;      // sym_start arrived mid-symbol
    logic                    w_last;       // consumed sample completes a symbol
    logic [3:0]              r_shift;
    logic [2:0]              r_bit_cnt;

    // Four-level decision with ties resolved toward the larger level
    function automatic logic [1:0] slice(input logic signed [ACC_W-1:0] acc);
        if (acc >= c_TH_POS)    return 2'b10;
        else if (acc >= c_ZERO) return 2'b11;
        else if (acc >= c_TH_NEG) return 2'b01;
        else                    return 2'b00;
    endfunction

    assign w_s_ext = {{(ACC_W-IN_W){signal[IN_W-1]}}, signal};

    // State register
    always_ff @(posedge carrier_clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (sample_valid && sym_start) w_state_nxt = S_ACQ;
            S_ACQ:  if (sample_valid && !sym_start && (r_idx == c_IDX_LAST)) w_state_nxt = S_DUMP;
            S_DUMP: w_state_nxt = sample_valid ? S_ACQ : S_WAIT;
            S_WAIT: if (sample_valid) w_state_nxt = S_ACQ;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Per-state sample qualification; DUMP and WAIT treat any valid sample as index 0
    always_comb begin
        w_take  = 1'b0;
        w_first = 1'b0;
        w_abort = 1'b0;
        w_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_take  = sample_valid && sym_start;
                w_first = sample_valid && sym_start;
            end
            S_ACQ: begin
                w_take  = sample_valid;
                w_abort = sample_valid && sym_start;
                w_first = sample_valid && sym_start;
                w_last  = sample_valid && !sym_start && (r_idx == c_IDX_LAST);
            end
            default: begin
                w_take  = sample_valid;
                w_first = sample_valid;
            end
        endcase
    end

    // Carrier mixing: index 0 loads the accumulators so symbols abut without a bubble
    always_comb begin
        w_acc_i_nxt = r_acc_i;
        w_acc_q_nxt = r_acc_q;
        if (w_first) begin
            w_acc_i_nxt = w_s_ext;
            w_acc_q_nxt = c_ZERO;
        end else begin
            case (r_idx[1:0])
                2'd0:    w_acc_i_nxt = r_acc_i + w_s_ext;
                2'd1:    w_acc_q_nxt = r_acc_q + w_s_ext;
                2'd2:    w_acc_i_nxt = r_acc_i - w_s_ext;
                default: w_acc_q_nxt = r_acc_q - w_s_ext;
            endcase
        end
    end

    // Integrate, dump decisions and track framing errors
    always_ff @(posedge carrier_clk) begin
        if (reset) begin
            r_idx     <= '0;
            r_acc_i   <= '0;
            r_acc_q   <= '0;
            sym_i     <= 2'b00;
            sym_q     <= 2'b00;
            sym_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            sym_valid <= w_last;
            if (w_take) begin
                r_acc_i <= w_acc_i_nxt;
                r_acc_q <= w_acc_q_nxt;
                if (w_last)       r_idx <= '0;
                else if (w_first) r_idx <= c_IDX_ONE;
                else              r_idx <= r_idx + 1'b1;
            end
            if (w_last) begin
                sym_i <= slice(w_acc_i_nxt);
                sym_q <= slice(w_acc_q_nxt);
            end
            if (w_abort) sync_err <= 1'b1;
        end
    end

    // Serialiser: loads during the sym_valid cycle, shifts out MSB first
    always_ff @(posedge carrier_clk) begin
        if (reset) begin
            r_shift   <= 4'b0000;
            r_bit_cnt <= 3'd0;
        end else if (sym_valid) begin
            r_shift   <= {sym_i, sym_q};
            r_bit_cnt <= 3'd4;
        end else if (r_bit_cnt != 3'd0) begin
            r_shift   <= {r_shift[2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - 3'd1;
        end
    end

    assign bit_valid = (r_bit_cnt != 3'd0);
    assign bit_out   = bit_valid & r_shift[3];

endmodule
`default_nettype wire

// File: tb/tb_qam16_coherent_demod.sv
`default_nettype none
// ============================================================================
// Module  : tb_qam16_coherent_demod
// Brief   : Randomised bench for qam16_coherent_demod with a sample-list
//           reference model checked every cycle plus directed checks.
// Revision: 1.0 - initial release
// ============================================================================
module tb_qam16_coherent_demod;

    localparam int IN_W    = 9;
    localparam int SPS     = 16;
    localparam int LEVEL_A = 32;
    localparam int TH      = LEVEL_A * SPS;
    localparam int MAXC    = 8192;
    localparam int LV[4]   = '{-3, -1, 1, 3};
    localparam int COS[4]  = '{1, 0, -1, 0};
    localparam int SIN[4]  = '{0, 1, 0, -1};

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic signed [IN_W-1:0] signal = '0;
    logic                   sample_valid = 1'b0;
    logic                   sym_start = 1'b0;
    logic [1:0]             sym_i;
    logic [1:0]             sym_q;
    logic                   sym_valid;
    logic                   bit_out;
    logic                   bit_valid;
    logic                   sync_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_sv_cyc = 0;

    // reference model state
    int         smp[$];
    bit         locked = 1'b0;
    bit         m_sv = 1'b0;
    bit         m_err = 1'b0;
    logic [1:0] m_si = 2'b00;
    logic [1:0] m_sq = 2'b00;
    int         m_s, m_ai, m_aq;
    logic [3:0] m_word;
    bit         exp_bv[MAXC];
    bit         exp_bo[MAXC];

    int buf_s[SPS];
    int gap[SPS];

    qam16_coherent_demod #(.IN_W(IN_W), .SPS(SPS), .LEVEL_A(LEVEL_A)) dut (
        .carrier_clk (clk),
        .reset       (reset),
        .signal      (signal),
        .sample_valid(sample_valid),
        .sym_start   (sym_start),
        .sym_i       (sym_i),
        .sym_q       (sym_q),
        .sym_valid   (sym_valid),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    // Amplitude level to Gray dibit
    function automatic logic [1:0] gray_of(input int acc);
        int lvl;
        if (acc >= TH)       lvl = 3;
        else if (acc >= 0)   lvl = 1;
        else if (acc >= -TH) lvl = -1;
        else                 lvl = -3;
        case (lvl)
            3:       return 2'b10;
            1:       return 2'b11;
            -1:      return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Reference model: collects accepted samples of a symbol, correlates on completion
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            m_sv = 1'b0;
            if (reset) begin
                smp.delete();
                locked = 1'b0;
                m_si = 2'b00;
                m_sq = 2'b00;
                m_err = 1'b0;
                for (int b = 0; b < 5; b++)
                    if (cyc + b < MAXC) begin
                        exp_bv[cyc+b] = 1'b0;
                        exp_bo[cyc+b] = 1'b0;
                    end
            end else if (sample_valid) begin
                m_s = int'(signal);
                if (!locked) begin
                    if (sym_start) begin
                        locked = 1'b1;
                        smp.delete();
                        smp.push_back(m_s);
                    end
                end else begin
                    if (sym_start && smp.size() != 0) begin
                        m_err = 1'b1;
                        smp.delete();
                    end
                    smp.push_back(m_s);
                    if (smp.size() == SPS) begin
                        m_ai = 0;
                        m_aq = 0;
                        for (int k = 0; k < SPS; k++) begin
                            m_ai += smp[k] * COS[k%4];
                            m_aq += smp[k] * SIN[k%4];
                        end
                        m_si = gray_of(m_ai);
                        m_sq = gray_of(m_aq);
                        m_sv = 1'b1;
                        m_word = {m_si, m_sq};
                        for (int b = 0; b < 4; b++)
                            if (cyc + 1 + b < MAXC) begin
                                exp_bv[cyc+1+b] = 1'b1;
                                exp_bo[cyc+1+b] = m_word[3-b];
                            end
                        smp.delete();
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (sym_valid === 1'b1) last_sv_cyc = cyc;
            if (cyc > 0 && cyc < MAXC) begin
                chk("sym_valid", sym_valid, m_sv);
                chk("sym_i", sym_i, m_si);
                chk("sym_q", sym_q, m_sq);
                chk("sync_err", sync_err, m_err);
                chk("bit_valid", bit_valid, exp_bv[cyc]);
                chk("bit_out", bit_out, exp_bo[cyc]);
            end
        end
    end

    task automatic drive(input int s, input bit v, input bit st);
        @(negedge clk);
        signal       = s[IN_W-1:0];
        sample_valid = v;
        sym_start    = st;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0);
    endtask

    // Ideal modulator samples for levels (li, lq) plus uniform noise
    task automatic fill_point(input int li, input int lq, input int noise);
        int base;
        for (int k = 0; k < SPS; k++) begin
            case (k % 4)
                0:       base = li * LEVEL_A;
                1:       base = lq * LEVEL_A;
                2:       base = -li * LEVEL_A;
                default: base = -lq * LEVEL_A;
            endcase
            buf_s[k] = base + int'($urandom_range(0, 2 * noise)) - noise;
        end
    endtask

    task automatic fill_raw(input int p0, input int p1, input int p2, input int p3);
        for (int k = 0; k < SPS; k++)
            case (k % 4)
                0:       buf_s[k] = p0;
                1:       buf_s[k] = p1;
                2:       buf_s[k] = p2;
                default: buf_s[k] = p3;
            endcase
    endtask

    // Sends n samples of buf_s, honouring gap[] idle cycles before each sample
    task automatic send_buf(input bit start, input int n, output int d0);
        d0 = 0;
        for (int k = 0; k < n; k++) begin
            if (gap[k] > 0) idle(gap[k]);
            drive(buf_s[k], 1'b1, start && (k == 0));
            if (k == 0) d0 = cyc;
        end
        for (int k = 0; k < SPS; k++) gap[k] = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, word, nb, r, t, n;
        int ord[16];
        for (int k = 0; k < SPS; k++) gap[k] = 0;
        reset = 1'b1;
        idle(3);
        chk("rst_sym_i", sym_i, 0);
        chk("rst_bit_valid", bit_valid, 0);
        reset = 1'b0;
        idle(2);

        // single symbol I=+3, Q=-1
        fill_point(3, -1, 0);
        send_buf(1'b1, SPS, d0);
        word = 0; nb = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0);
            if (bit_valid === 1'b1) begin word = (word << 1) | int'(bit_out); nb++; end
        end
        chk("t1_sym_i", sym_i, 2'b10);
        chk("t1_sym_q", sym_q, 2'b01);
        chk("t1_bits", word, 4'b1001);
        chk("t1_nbits", nb, 4);
        chk("t1_latency", last_sv_cyc - d0, SPS);

        // all 16 points back-to-back, shuffled, one sym_start
        for (int j = 0; j < 16; j++) ord[j] = j;
        for (int j = 15; j > 0; j--) begin
            r = int'($urandom_range(0, j));
            t = ord[j]; ord[j] = ord[r]; ord[r] = t;
        end
        for (int j = 0; j < 16; j++) begin
            fill_point(LV[ord[j]/4], LV[ord[j]%4], 4);
            send_buf(j == 0, SPS, d0);
        end
        idle(8);
        chk("t2_sync_err", sync_err, 0);

        // slicer boundaries
        fill_raw(64, 32, -64, -32);
        send_buf(1'b1, SPS, d0);
        idle(6);
        chk("t3_i512", sym_i, 2'b10);
        chk("t3_q256", sym_q, 2'b11);
        fill_raw(0, -64, 0, 64);
        send_buf(1'b1, SPS, d0);
        idle(6);
        chk("t3_i0", sym_i, 2'b11);
        chk("t3_qm512", sym_q, 2'b01);
        fill_raw(96, -64, -96, 64);
        buf_s[5] = -65;
        send_buf(1'b1, SPS, d0);
        idle(6);
        chk("t3_i768", sym_i, 2'b10);
        chk("t3_qm513", sym_q, 2'b00);

        // five dropped sample_valid cycles mid-symbol
        fill_point(3, -1, 0);
        for (int i = 0; i < 5; i++) begin
            r = int'($urandom_range(1, SPS - 1));
            gap[r] = gap[r] + 1;
        end
        send_buf(1'b1, SPS, d0);
        idle(8);
        chk("t4_latency", last_sv_cyc - d0, SPS + 5);
        chk("t4_sym_i", sym_i, 2'b10);
        chk("t4_sym_q", sym_q, 2'b01);

        // sym_start reasserted at idx 7
        fill_point(LV[$urandom_range(0, 3)], LV[$urandom_range(0, 3)], 4);
        send_buf(1'b1, 7, d0);
        fill_point(1, 3, 4);
        send_buf(1'b1, SPS, d0);
        idle(8);
        chk("t5_sync_err", sync_err, 1);
        chk("t5_latency", last_sv_cyc - d0, SPS);
        chk("t5_sym_i", sym_i, 2'b11);
        chk("t5_sym_q", sym_q, 2'b10);

        // reset during bit 2 of serialisation
        fill_point(-3, 3, 4);
        send_buf(1'b1, SPS, d0);
        n = 0;
        while (bit_valid !== 1'b1 && n < 20) begin drive(0, 0, 0); n++; end
        chk("t6_bits_seen", bit_valid, 1);
        drive(0, 0, 0);
        reset = 1'b1;
        drive(0, 0, 0);
        reset = 1'b0;
        chk("t6_bit_valid", bit_valid, 0);
        chk("t6_sym_i", sym_i, 0);
        chk("t6_sync_err", sync_err, 0);
        fill_point(3, 3, 4);
        send_buf(1'b0, SPS, d0);
        idle(6);
        chk("t6_ignored", sym_q, 0);
        fill_point(-1, 1, 4);
        send_buf(1'b1, SPS, d0);
        idle(8);
        chk("t6_rec_i", sym_i, 2'b01);
        chk("t6_rec_q", sym_q, 2'b11);

        // random symbols with random valid gaps and inter-symbol idles
        for (int j = 0; j < 8; j++) begin
            fill_point(LV[$urandom_range(0, 3)], LV[$urandom_range(0, 3)], 8);
            for (int k = 1; k < SPS; k++) gap[k] = ($urandom_range(0, 3) == 0) ? 1 : 0;
            send_buf($urandom_range(0, 1) == 1, SPS, d0);
            idle(int'($urandom_range(0, 3)));
        end
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
